// File: rtl/tex_pkg.sv
// ---------------------------------------------------------------------------
// tex_pkg
// Shared constants and types for the 64x64 RGB888 texture RAM.
// The loader (port A writer) and the texture mapper (port B reader) both take
// the geometry and address width from here.
//
// Contents:
//   TEX_W, TEX_H      texture geometry in texels
//   ADDR_W, DATA_W    RAM port widths
//   X_W, Y_W          column / row counter widths; address = {y, x}
//   BYTES_PER_TEXEL   host bytes per texel (3 for RGB888, 2 for RGB565)
//   load_state_t      loader FSM state encoding
//   rgb565_to_rgb888  RGB565 -> RGB888 expansion (replicates the top bits)
//
// Build option: TEX_LOAD_RGB565_EN selects the 2-byte RGB565 host format.
// ---------------------------------------------------------------------------
package tex_pkg;

  localparam int TEX_W  = 64;
  localparam int TEX_H  = 64;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;

  localparam int X_W = $clog2(TEX_W);
  localparam int Y_W = ADDR_W - X_W;

`ifdef TEX_LOAD_RGB565_EN
  localparam int BYTES_PER_TEXEL = 2;
`else
  localparam int BYTES_PER_TEXEL = 3;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } load_state_t;

  // Low bits are filled by repeating the channel MSBs so full scale maps to 8'hFF.
  function automatic logic [DATA_W-1:0] rgb565_to_rgb888(input logic [15:0] px);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = px[15:11];
    g6 = px[10:5];
    b5 = px[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/tex_buffer_loader_if.sv
// ---------------------------------------------------------------------------
// tex_buffer_loader_if
// Host byte stream into the texture loader (valid/ready handshake).
// A byte transfers on a clock edge where valid && ready.
//
// Signals:
//   valid  host has a byte on data
//   ready  loader takes the byte this cycle
//   data   host byte
// Modports:
//   master  host side   (drives valid, data)
//   slave   loader side (drives ready)
// ---------------------------------------------------------------------------
interface tex_buffer_loader_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tex_byte_packer.sv
// ---------------------------------------------------------------------------
// tex_byte_packer
// Counts accepted host bytes, steers them into colour lanes and presents the
// finished texel in the same cycle its last byte is accepted.
//
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   clear_i          drop any partial texel and restart at lane 0
//   byte_accept_i    a host byte is transferred this cycle
//   byte_data_i      the host byte
//   texel_o          packed RGB888 texel (valid only with texel_valid_o)
//   texel_valid_o    last byte of a texel is being accepted now
//
// Build option: TEX_LOAD_RGB565_EN packs 2 bytes (high first) as RGB565 and
// expands to RGB888; otherwise 3 bytes in R, G, B order.
// ---------------------------------------------------------------------------
module tex_byte_packer
  import tex_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              byte_accept_i,
  input  logic [7:0]        byte_data_i,
  output logic [DATA_W-1:0] texel_o,
  output logic              texel_valid_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_TEXEL - 1);

  logic [1:0] lane_q;
  logic [7:0] hi_q;
  logic       last_lane;
  logic       take;

  assign last_lane     = (lane_q == LAST_LANE);
  assign take          = byte_accept_i && !clear_i;
  assign texel_valid_o = take && last_lane;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lane_q <= 2'd0;
    end else if (clear_i) begin
      lane_q <= 2'd0;
    end else if (byte_accept_i) begin
      lane_q <= last_lane ? 2'd0 : lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hi_q <= 8'd0;
    end else if (take && (lane_q == 2'd0)) begin
      hi_q <= byte_data_i;
    end
  end

`ifdef TEX_LOAD_RGB565_EN
  // The final byte is used directly, so no storage is needed beyond the high byte.
  assign texel_o = rgb565_to_rgb888({hi_q, byte_data_i});
`else
  logic [7:0] mid_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mid_q <= 8'd0;
    end else if (take && (lane_q == 2'd1)) begin
      mid_q <= byte_data_i;
    end
  end

  assign texel_o = {hi_q, mid_q, byte_data_i};
`endif

endmodule

// File: rtl/tex_buffer_loader.sv
// ---------------------------------------------------------------------------
// tex_buffer_loader
// Port A writer for the 64x64x24 texture RAM. Packs the host byte stream into
// texels and writes them row-major at {y, x}; tex_loaded_o tells the mapper a
// complete texture is resident.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   load_start_i   pulse, starts a load (IDLE only; abort wins if both)
//   load_abort_i   pulse, cancels the load (a pending write still completes)
//   byte_if        host byte stream, slave side (ready only in COLLECT)
//   tex_wea_o      RAM write enable, one cycle per texel
//   tex_addra_o    RAM address, registered, held between writes
//   tex_dina_o     RAM write data, registered, held between writes
//   busy_o         state != IDLE
//   load_done_o    pulse after the last texel is written
//   tex_loaded_o   level, complete texture resident
//
// Build option: TEX_LOAD_RGB565_EN selects 2-byte RGB565 texels.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for load_start_i
// COLLECT | accepting host bytes for the current texel
// WRITE   | one-cycle RAM write of the registered texel, then advance
// DONE    | last texel written; pulse load_done_o, set tex_loaded_o
// ---------------------------------------------------------------------------
module tex_buffer_loader
  import tex_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_start_i,
  input  logic               load_abort_i,
  tex_buffer_loader_if.slave byte_if,
  output logic               tex_wea_o,
  output logic [ADDR_W-1:0]  tex_addra_o,
  output logic [DATA_W-1:0]  tex_dina_o,
  output logic               busy_o,
  output logic               load_done_o,
  output logic               tex_loaded_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(TEX_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(TEX_H - 1);

  load_state_t       state_q;
  load_state_t       state_d;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              last_texel;
  logic              start_ok;
  logic              collect_abort;
  logic              byte_ready;
  logic              byte_accept;
  logic              packer_clear;
  logic [DATA_W-1:0] texel;
  logic              texel_valid;

  assign last_texel    = (x_q == X_MAX) && (y_q == Y_MAX);
  assign start_ok      = (state_q == ST_IDLE) && load_start_i && !load_abort_i;
  assign collect_abort = (state_q == ST_COLLECT) && load_abort_i;
  assign byte_accept   = byte_if.valid && byte_ready;
  assign packer_clear  = start_ok || collect_abort;
  assign byte_if.ready = byte_ready;

  tex_byte_packer u_packer (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clear_i       (packer_clear),
    .byte_accept_i (byte_accept),
    .byte_data_i   (byte_if.data),
    .texel_o       (texel),
    .texel_valid_o (texel_valid)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (load_abort_i)     state_d = ST_IDLE;
        else if (texel_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // The write itself is already on the port this cycle; abort only
        // stops what happens after it.
        if (load_abort_i)    state_d = ST_IDLE;
        else if (last_texel) state_d = ST_DONE;
        else                 state_d = ST_COLLECT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    byte_ready  = (state_q == ST_COLLECT);
    tex_wea_o   = (state_q == ST_WRITE);
    load_done_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_ok) begin
      x_q <= '0;
      y_q <= '0;
    end else if ((state_q == ST_WRITE) && !last_texel) begin
      if (x_q == X_MAX) begin
        x_q <= '0;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // Address and data are captured with the last byte so WRITE needs no
  // extra cycle and the port holds steady between writes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tex_addra_o <= '0;
      tex_dina_o  <= '0;
    end else if (texel_valid) begin
      tex_addra_o <= {y_q, x_q};
      tex_dina_o  <= texel;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tex_loaded_o <= 1'b0;
    end else if (start_ok) begin
      tex_loaded_o <= 1'b0;
    end else if (state_q == ST_DONE) begin
      tex_loaded_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tex_buffer_loader.sv
// ---------------------------------------------------------------------------
// tb_tex_buffer_loader
// Bench for tex_buffer_loader. A texel-level model (byte list, texel index,
// pending write/done flags) predicts every output on every cycle; directed
// sequences add hand-computed literal checks on top.
// ---------------------------------------------------------------------------
module tb_tex_buffer_loader;
  import tex_pkg::*;

  localparam int TEXELS = TEX_W * TEX_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              busy;
  logic              load_done;
  logic              loaded;

  tex_buffer_loader_if bif ();

  int checks   = 0;
  int passed   = 0;
  int cyc      = 0;
  int wea_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tex_buffer_loader dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .load_start_i (load_start),
    .load_abort_i (load_abort),
    .byte_if      (bif),
    .tex_wea_o    (wea),
    .tex_addra_o  (addra),
    .tex_dina_o   (dina),
    .busy_o       (busy),
    .load_done_o  (load_done),
    .tex_loaded_o (loaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] model_pack(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
    int w, r5, g6, b5;
    if (BYTES_PER_TEXEL == 2) begin
      w  = b0 * 256 + b1;
      r5 = w / 2048;
      g6 = (w / 32) % 64;
      b5 = w % 32;
      return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
    end
    return {b0, b1, b2};
  endfunction

  // ---------------- model ----------------
  logic              m_active, m_wr, m_done, m_loaded;
  int                m_nb, m_idx;
  logic [7:0]        m_lane [3];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;

  always @(negedge clk) begin
    logic n_wr, n_done;
    if (rst) begin
      m_active = 0; m_wr = 0; m_done = 0; m_loaded = 0;
      m_nb = 0; m_idx = 0; m_addr = '0; m_din = '0;
      m_lane[0] = 0; m_lane[1] = 0; m_lane[2] = 0;
    end
    chk("ready",  32'(bif.ready), 32'(m_active && !m_wr && !m_done));
    chk("wea",    32'(wea),       32'(m_wr));
    chk("busy",   32'(busy),      32'(m_active || m_wr || m_done));
    chk("done",   32'(load_done), 32'(m_done));
    chk("loaded", 32'(loaded),    32'(m_loaded));
    chk("addr",   32'(addra),     32'(m_addr));
    chk("din",    32'(dina),      32'(m_din));
    if (wea === 1'b1) wea_cnt++;
    if (load_done === 1'b1) done_cnt++;
    if (!rst) begin
      n_wr = 0; n_done = 0;
      if (m_done) begin
        m_loaded = 1; m_active = 0;
      end else if (m_wr) begin
        if (load_abort) m_active = 0;
        else if (m_idx == TEXELS - 1) begin n_done = 1; m_active = 0; end
        else m_idx++;
      end else if (m_active) begin
        if (load_abort) begin
          m_active = 0; m_nb = 0;
        end else if (bif.valid) begin
          m_lane[m_nb] = bif.data;
          m_nb++;
          if (m_nb == BYTES_PER_TEXEL) begin
            m_addr = ADDR_W'(m_idx);
            m_din  = model_pack(m_lane[0], m_lane[1], m_lane[2]);
            m_nb   = 0;
            n_wr   = 1;
          end
        end
      end else if (load_start && !load_abort) begin
        m_active = 1; m_idx = 0; m_nb = 0; m_loaded = 0;
      end
      m_wr = n_wr; m_done = n_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, output int hs_cyc);
    logic rdy;
    logic got;
    got = 0; hs_cyc = -1;
    for (int g = 0; g < gap; g++) begin
      bif.valid = 0;
      @(posedge clk); #1;
    end
    bif.valid = 1; bif.data = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); rdy = bif.ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) begin got = 1; hs_cyc = cyc; end
    end
    bif.valid = 0;
    if (!got) chk("byte_handshake_timeout", 32'(got), 32'd1);
  endtask

  task automatic pulse_start();
    load_start = 1; @(posedge clk); #1; load_start = 0;
  endtask

  task automatic pulse_abort();
    load_abort = 1; @(posedge clk); #1; load_abort = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, w0, hc;
    logic ok;
    logic [7:0]  t1 [3];
    logic [23:0] t1_exp, aa_exp;
`ifdef TEX_LOAD_RGB565_EN
    t1[0] = 8'hF8; t1[1] = 8'h1F; t1[2] = 8'h00; t1_exp = 24'hFF00FF; aa_exp = 24'hAD5552;
`else
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1_exp = 24'h112233; aa_exp = 24'hAAAAAA;
`endif
    bif.valid = 0; bif.data = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);      chk("rst_ready", 32'(bif.ready), 0);
    chk("rst_wea", 32'(wea), 0);        chk("rst_addr", 32'(addra), 0);
    chk("rst_din", 32'(dina), 0);       chk("rst_done", 32'(load_done), 0);
    chk("rst_loaded", 32'(loaded), 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // first texel, write latency and next-byte acceptance
    pulse_start();
    for (int b = 0; b < BYTES_PER_TEXEL; b++) send_byte(t1[b], 0, c1);
    bif.valid = 1; bif.data = 8'h44;
    @(negedge clk);
    chk("t1_wea", 32'(wea), 1); chk("t1_addr", 32'(addra), 0); chk("t1_din", 32'(dina), 32'(t1_exp));
    chk("t1_ready_in_write", 32'(bif.ready), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t1_next_ready", 32'(bif.ready), 1);
    @(posedge clk); #1; c2 = cyc; bif.valid = 0;
    chk("t1_next_byte_latency", 32'(c2 - c1), 32'd2);
    pulse_abort();
    @(negedge clk); chk("t1_abort_busy", 32'(busy), 0); chk("t1_abort_loaded", 32'(loaded), 0);
    @(posedge clk); #1;

    // full load with 50% valid gaps early on and a stray start mid-load
    w0 = wea_cnt;
    pulse_start();
    for (int t = 0; t < TEXELS; t++) begin
      if (t == 100) pulse_start();
      for (int b = 0; b < BYTES_PER_TEXEL; b++)
        send_byte(8'(t), (t < 32 && (b % 2) == 1) ? 1 : 0, hc);
      if (t == 63 || t == 64) begin
        @(negedge clk);
        chk((t == 63) ? "wrap_addr63" : "wrap_addr64", 32'(addra), 32'(t));
        chk("wrap_wea", 32'(wea), 1);
        @(posedge clk); #1;
      end
    end
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) ok = 1;
    end
    chk("full_done_seen", 32'(ok), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_loaded", 32'(loaded), 1);  chk("full_busy", 32'(busy), 0);
    chk("full_wea_count", 32'(wea_cnt - w0), 32'(TEXELS));
    chk("full_done_count", 32'(done_cnt), 1);
    @(posedge clk); #1;

    // abort partway through texel 5
    pulse_start();
    for (int t = 0; t < 5; t++)
      for (int b = 0; b < BYTES_PER_TEXEL; b++) send_byte(8'(t), 0, hc);
    for (int b = 0; b < BYTES_PER_TEXEL - 1; b++) send_byte(8'h05, 0, hc);
    w0 = wea_cnt;
    pulse_abort();
    bif.valid = 1; bif.data = 8'h77;
    repeat (10) @(posedge clk);
    #1; bif.valid = 0;
    @(negedge clk);
    chk("abort_no_wea", 32'(wea_cnt - w0), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_loaded", 32'(loaded), 0);
    @(posedge clk); #1;

    // restart writes from address 0
    pulse_start();
    for (int b = 0; b < BYTES_PER_TEXEL; b++) send_byte(8'hAA, 0, hc);
    @(negedge clk);
    chk("restart_addr", 32'(addra), 0); chk("restart_din", 32'(dina), 32'(aa_exp));
    chk("restart_wea", 32'(wea), 1);
    @(posedge clk); #1;

    // async reset mid-texel
    send_byte(8'h01, 0, hc);
    #2 rst = 1;
    @(negedge clk);
    chk("arst_busy", 32'(busy), 0);     chk("arst_ready", 32'(bif.ready), 0);
    chk("arst_wea", 32'(wea), 0);       chk("arst_addr", 32'(addra), 0);
    chk("arst_din", 32'(dina), 0);      chk("arst_done", 32'(load_done), 0);
    chk("arst_loaded", 32'(loaded), 0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("final_busy", 32'(busy), 0);
    chk("final_done_count", 32'(done_cnt), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
